// File: rtl/prog_sequencer.sv
// Instruction sequencer feeding the 8-bit Processador: issues program words, waits out
// EXEC_LAT, captures result/flags per address. Optional macro RESULT_CHAIN_EN forwards results.
module prog_sequencer #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int EXEC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [23:0]       load_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        opcode_o,
    output logic [7:0]        operand1_o,
    output logic [7:0]        operand2_o,
    input  logic [7:0]        alu_result_i,
    input  logic [7:0]        alu_flags_i,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_addr,
    output logic [7:0]        res_data,
    output logic [7:0]        res_flags
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [2:0]        LAT     = 3'(EXEC_LAT);
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [23:0]       mem [DEPTH];
    logic [ADDR_W-1:0] pc_nxt;
    logic [23:0]       word0, nxt_word;
    logic [7:0]        first_op, first_op1, next_op, next_op1;

    assign pc_nxt   = pc + ADDR_W'(1);
    assign word0    = mem[0];
    assign nxt_word = mem[pc_nxt];

`ifdef RESULT_CHAIN_EN
    // Chained words take operand1 from the result being captured on the same edge;
    // the first word after start has no prior result, so it sees 0.
    assign first_op  = {1'b0, word0[22:16]};
    assign first_op1 = word0[23] ? 8'h00 : word0[15:8];
    assign next_op   = {1'b0, nxt_word[22:16]};
    assign next_op1  = nxt_word[23] ? alu_result_i : nxt_word[15:8];
`else
    assign first_op  = word0[23:16];
    assign first_op1 = word0[15:8];
    assign next_op   = nxt_word[23:16];
    assign next_op1  = nxt_word[15:8];
`endif

    // Program memory survives reset; a same-cycle start reads the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pc         <= '0;
            opcode_o   <= '0;
            operand1_o <= '0;
            operand2_o <= '0;
            res_valid  <= 1'b0;
            res_addr   <= '0;
            res_data   <= '0;
            res_flags  <= '0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (word0[23:16] == 8'h00) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            opcode_o <= 8'h00;
                        end else begin
                            opcode_o   <= first_op;
                            operand1_o <= first_op1;
                            operand2_o <= word0[7:0];
                            pc         <= '0;
                            cnt        <= '0;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAT) begin
                        res_valid <= 1'b1;
                        res_addr  <= pc;
                        res_data  <= alu_result_i;
                        res_flags <= alu_flags_i;
                        if (pc == PC_LAST || nxt_word[23:16] == 8'h00) begin
                            // done is raised with the final capture; busy drops when DONE ends
                            state    <= DONE;
                            done     <= 1'b1;
                            opcode_o <= 8'h00;
                            cnt      <= '0;
                        end else begin
                            opcode_o   <= next_op;
                            operand1_o <= next_op1;
                            operand2_o <= nxt_word[7:0];
                            pc         <= pc_nxt;
                            cnt        <= '0;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
